// File: rtl/bufgce_clk_gate_if.sv
`default_nettype none
// ============================================================================
// Module      : bufgce_clk_gate_if
// Description : Enable, override and statistics bundle of the gated clock
//               buffer. The buffer drives the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bufgce_clk_gate_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 ce;
    logic                 test_en;
    logic                 clr_cnt;
    logic                 o;
    logic                 en_q;
    logic [CNT_WIDTH-1:0] active_cycles;
    logic [CNT_WIDTH-1:0] gated_cycles;

    modport master (
        output ce, test_en, clr_cnt,
        input  o, en_q, active_cycles, gated_cycles
    );

    modport slave (
        input  ce, test_en, clr_cnt,
        output o, en_q, active_cycles, gated_cycles
    );
endinterface
`default_nettype wire

// File: rtl/bufgce_clk_gate.sv
`default_nettype none
// ============================================================================
// Module      : bufgce_clk_gate
// Description : Glitch-free latch-based clock gate with scan override and
//               saturating active/gated edge counters. Optional macro
//               BUFGCE_CE_SYNC_EN adds a 2-flop synchronizer on ce.
// Revision    : 1.0 - initial release
// ============================================================================
module bufgce_clk_gate #(
    parameter bit IS_CE_INVERTED = 1'b0,
    parameter int CNT_WIDTH      = 16
) (
    input  wire                     clk,
    input  wire                     rst_n,
    bufgce_clk_gate_if.slave        gate_if
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    logic w_ce_src;
    logic w_e;
    logic r_en_latch;

`ifdef BUFGCE_CE_SYNC_EN
    logic r_ce_meta;
    logic r_ce_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce_meta <= 1'b0;
            r_ce_sync <= 1'b0;
        end else begin
            r_ce_meta <= gate_if.ce;
            r_ce_sync <= r_ce_meta;
        end
    end

    assign w_ce_src = r_ce_sync;
`else
    assign w_ce_src = gate_if.ce;
`endif

    // test_en is kept outside the synchronizer so scan always sees zero latency
    assign w_e = (w_ce_src ^ IS_CE_INVERTED) | gate_if.test_en;

    // Transparent only in the low phase so enable edges never reach a high pulse
    always_latch begin
        if (!rst_n) begin
            r_en_latch <= 1'b0;
        end else if (!clk) begin
            r_en_latch <= w_e;
        end
    end

    assign gate_if.o    = clk & r_en_latch;
    assign gate_if.en_q = r_en_latch;

    // Index 0 counts passed edges, index 1 counts suppressed edges
    logic [CNT_WIDTH-1:0] r_cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_cnt
        logic w_hit;
        assign w_hit = (g == 0) ? r_en_latch : ~r_en_latch;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[g] <= '0;
            end else if (gate_if.clr_cnt) begin
                r_cnt[g] <= '0;
            end else if (w_hit && (r_cnt[g] != c_CNT_MAX)) begin
                r_cnt[g] <= r_cnt[g] + c_CNT_ONE;
            end
        end
    end

    assign gate_if.active_cycles = r_cnt[0];
    assign gate_if.gated_cycles  = r_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_bufgce_clk_gate.sv
`default_nettype none
// Bench for bufgce_clk_gate: default instance (A) and inverted 4-bit instance (B)
// share stimulus and are compared each cycle against an edge-level model.
module tb_bufgce_clk_gate;

    localparam int MAX_A = 65535;
    localparam int MAX_B = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b1;
    logic test_en = 1'b0;
    logic clr_cnt = 1'b0;

    int total = 0;
    int bad = 0;

    bufgce_clk_gate_if #(.CNT_WIDTH(16)) if_a ();
    bufgce_clk_gate_if #(.CNT_WIDTH(4))  if_b ();

    assign if_a.ce = ce;      assign if_b.ce = ce;
    assign if_a.test_en = test_en; assign if_b.test_en = test_en;
    assign if_a.clr_cnt = clr_cnt; assign if_b.clr_cnt = clr_cnt;

    bufgce_clk_gate #(.IS_CE_INVERTED(1'b0), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .gate_if(if_a.slave)
    );
    bufgce_clk_gate #(.IS_CE_INVERTED(1'b1), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .gate_if(if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edge-level model: what each rising edge must do given the inputs before it
    logic exp_en_a = 1'b0;
    logic exp_en_b = 1'b0;
    int   m_act_a = 0, m_gat_a = 0, m_act_b = 0, m_gat_b = 0;
`ifdef BUFGCE_CE_SYNC_EN
    logic h1 = 1'b0, h2 = 1'b0;
`endif

    function automatic logic enable_of(input logic c, input logic inv, input logic t);
        return (c ^ inv) | t;
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v == max) ? v : v + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_en_a <= 1'b0; exp_en_b <= 1'b0;
            m_act_a <= 0; m_gat_a <= 0; m_act_b <= 0; m_gat_b <= 0;
`ifdef BUFGCE_CE_SYNC_EN
            h1 <= 1'b0; h2 <= 1'b0;
`endif
        end else begin
`ifdef BUFGCE_CE_SYNC_EN
            exp_en_a <= enable_of(h2, 1'b0, test_en);
            exp_en_b <= enable_of(h2, 1'b1, test_en);
            h2 <= h1;
            h1 <= ce;
            if (clr_cnt) begin
                m_act_a <= 0; m_gat_a <= 0; m_act_b <= 0; m_gat_b <= 0;
            end else begin
                if (enable_of(h2, 1'b0, test_en)) m_act_a <= sat_inc(m_act_a, MAX_A);
                else                               m_gat_a <= sat_inc(m_gat_a, MAX_A);
                if (enable_of(h2, 1'b1, test_en)) m_act_b <= sat_inc(m_act_b, MAX_B);
                else                               m_gat_b <= sat_inc(m_gat_b, MAX_B);
            end
`else
            exp_en_a <= enable_of(ce, 1'b0, test_en);
            exp_en_b <= enable_of(ce, 1'b1, test_en);
            if (clr_cnt) begin
                m_act_a <= 0; m_gat_a <= 0; m_act_b <= 0; m_gat_b <= 0;
            end else begin
                if (enable_of(ce, 1'b0, test_en)) m_act_a <= sat_inc(m_act_a, MAX_A);
                else                               m_gat_a <= sat_inc(m_gat_a, MAX_A);
                if (enable_of(ce, 1'b1, test_en)) m_act_b <= sat_inc(m_act_b, MAX_B);
                else                               m_gat_b <= sat_inc(m_gat_b, MAX_B);
            end
`endif
        end
    end

    // Compare process: early and late in each high phase, and in each low phase
    always begin
        @(posedge clk);
        #1;
        chk("o_a",      32'(if_a.o),             32'(exp_en_a));
        chk("en_q_a",   32'(if_a.en_q),          32'(exp_en_a));
        chk("active_a", 32'(if_a.active_cycles), m_act_a);
        chk("gated_a",  32'(if_a.gated_cycles),  m_gat_a);
        chk("o_b",      32'(if_b.o),             32'(exp_en_b));
        chk("en_q_b",   32'(if_b.en_q),          32'(exp_en_b));
        chk("active_b", 32'(if_b.active_cycles), m_act_b);
        chk("gated_b",  32'(if_b.gated_cycles),  m_gat_b);
        #3;
        chk("o_a_late", 32'(if_a.o), 32'(exp_en_a));
        chk("o_b_late", 32'(if_b.o), 32'(exp_en_b));
        @(negedge clk);
        #1;
        chk("o_a_low", 32'(if_a.o), 32'd0);
        chk("o_b_low", 32'(if_b.o), 32'd0);
    end

    int pulses_a = 0, pulses_b = 0;
    always @(posedge if_a.o) pulses_a <= pulses_a + 1;
    always @(posedge if_b.o) pulses_b <= pulses_b + 1;

    int    width_err = 0;
    time   t_rise;
    always begin
        @(posedge if_a.o);
        t_rise = $time;
        @(negedge if_a.o);
        if ($time - t_rise != 5) width_err++;
    end

    int p0, q0, a0;
    logic win_pat [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic lat_exp [3];

    initial begin
        // Reset held with ce high
        repeat (5) @(negedge clk);
        chk("rst_pulses_a", 32'(pulses_a), 32'd0);
        chk("rst_active_a", 32'(if_a.active_cycles), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
`ifndef BUFGCE_CE_SYNC_EN
        chk("run10_active_a", 32'(if_a.active_cycles), 32'd10);
        chk("run10_pulses_a", 32'(pulses_a), 32'd10);
        chk("run10_gated_b",  32'(if_b.gated_cycles), 32'd10);
`endif

        // Enable window: 3 of 8 edges
        clr_cnt = 1'b1; ce = 1'b0;
        @(negedge clk);
        clr_cnt = 1'b0;
        p0 = pulses_a;
        for (int i = 0; i < 8; i++) begin
            ce = win_pat[i];
            @(negedge clk);
        end
`ifndef BUFGCE_CE_SYNC_EN
        chk("win_pulses_a", 32'(pulses_a - p0), 32'd3);
        chk("win_active_a", 32'(if_a.active_cycles), 32'd3);
        chk("win_gated_a",  32'(if_a.gated_cycles), 32'd5);
        chk("win_active_b", 32'(if_b.active_cycles), 32'd5);
`endif

        // ce moves only inside high phases
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2 ce = 1'b1;
            @(posedge clk); #2 ce = 1'b0;
        end
        @(negedge clk);
        chk("glitch_width_err", 32'(width_err), 32'd0);

        // Scan override
        ce = 1'b0; test_en = 1'b1;
        p0 = pulses_a; a0 = int'(if_a.active_cycles);
        repeat (4) @(negedge clk);
        chk("scan_pulses_a", 32'(pulses_a - p0), 32'd4);
        chk("scan_active_a", 32'(int'(if_a.active_cycles) - a0), 32'd4);

        // Inverted instance runs with ce low
        test_en = 1'b0;
        p0 = pulses_a; q0 = pulses_b;
        repeat (4) @(negedge clk);
        chk("inv_pulses_b", 32'(pulses_b - q0), 32'd4);
        chk("inv_pulses_a", 32'(pulses_a - p0), 32'd0);

        // Saturation of the 4-bit counters, then clear
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        repeat (20) @(negedge clk);
        chk("sat_active_b", 32'(if_b.active_cycles), 32'd15);
        chk("sat_gated_a",  32'(if_a.gated_cycles), 32'd20);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("clr_active_b", 32'(if_b.active_cycles), 32'd0);
        chk("clr_gated_a",  32'(if_a.gated_cycles), 32'd0);

        // Enable latency from ce rising before edge k
`ifdef BUFGCE_CE_SYNC_EN
        lat_exp = '{1'b0, 1'b0, 1'b1};
`else
        lat_exp = '{1'b1, 1'b1, 1'b1};
`endif
        ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("lat_edge_k+%0d", i), 32'(if_a.o), 32'(lat_exp[i]));
        end
        repeat (3) @(negedge clk);

        // Reset asserted mid high phase truncates the pulse
        @(posedge clk); #2;
        chk("pre_rst_o_a", 32'(if_a.o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_o_a",    32'(if_a.o), 32'd0);
        chk("mid_rst_en_q_a", 32'(if_a.en_q), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
